tone_detector: RTL

//   Receive-side counterpart of the square-wave note generator.
//   - Measures the rise-to-rise period of an external square wave (tone_in) in clk cycles.
//   - Classifies the period against a fixed 8-note table (C4..C5, 50 MHz clk).
//   - Reports a stable note index with a valid level and a change strobe.
//   - Sits between the pad/comparator input and the piano UI/scoring logic.

---
 rtl/tone_detector.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/tone_detector.sv
// tone_detector
//   Measures the rise-to-rise period of an external square wave in clk cycles,
//   classifies it against an 8-entry note table (C4..C5) and reports a stable
//   note once STABLE_CNT consecutive periods agree.
//
//   Optional feature: define GLITCH_FILTER_EN to insert a FILT_LEN-cycle
//   majority-free "N equal samples" filter between synchronizer and rise
//   detect. Without it every synchronized 0->1 counts as a rise.
//
// Ports
//   clk         in   system clock (50 MHz nominal)
//   rst_n       in   asynchronous active-low reset
//   tone_in     in   asynchronous square-wave input
//   period_out  out  last measured period in clk cycles
//   period_stb  out  1-cycle pulse when period_out updates
//   note_idx    out  locked note, 0=C4 .. 7=C5
//   note_valid  out  high while locked on note_idx
//   note_stb    out  1-cycle pulse on each entry to LOCKED
//   silence     out  high while idle (no edge yet or timed out)
//
// NOMINAL holds the table periods (entry 0 = C4) and must fit PERIOD_W bits;
// PERIOD_W is limited to 32.

module tone_detector #(
    parameter int PERIOD_W   = 18,
    parameter int MAX_PERIOD = 250000,
    parameter int TOL_SHIFT  = 6,
    parameter int STABLE_CNT = 4,
    parameter int FILT_LEN   = 3,
    parameter logic [7:0][31:0] NOMINAL = {32'd95557,  32'd101239, 32'd113636, 32'd127551,
                                           32'd143172, 32'd151688, 32'd170264, 32'd191113}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tone_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_stb,
    output logic [2:0]          note_idx,
    output logic                note_valid,
    output logic                note_stb,
    output logic                silence
);

    localparam int                  MW     = $clog2(STABLE_CNT + 1);
    localparam logic [PERIOD_W-1:0] MAX_P  = PERIOD_W'(MAX_PERIOD);
    localparam logic [MW-1:0]       LOCK_N = MW'(STABLE_CNT);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKING, LOCKED} state_t;

    // ---------------- input path ----------------
    logic [1:0] sync;
    logic       din, din_d, rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], tone_in};
    end

`ifdef GLITCH_FILTER_EN
    localparam int FCW = $clog2(FILT_LEN + 1);
    logic           filt;
    logic [FCW-1:0] fcnt;

    // Output follows the input only after FILT_LEN consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync[1] == filt) begin
            fcnt <= '0;
        end else if (fcnt == FCW'(FILT_LEN - 1)) begin
            filt <= sync[1];
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end
    assign din = filt;
`else
    assign din = sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_d <= 1'b0;
            rise  <= 1'b0;
        end else begin
            din_d <= din;
            rise  <= din & ~din_d;
        end
    end

    // ---------------- period counter ----------------
    logic [PERIOD_W-1:0] cnt, period;
    logic                timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (rise)          cnt <= '0;
        else if (cnt != MAX_P)  cnt <= cnt + 1'b1;
    end

    // cnt is cleared the cycle after a rise, so the rise cycle itself is +1.
    assign period  = cnt + 1'b1;
    assign timeout = (cnt == MAX_P);

    // ---------------- classification ----------------
    logic [7:0] match;
    logic       hit;
    logic [2:0] idx;

    for (genvar g = 0; g < 8; g++) begin : g_cls
        localparam logic [PERIOD_W-1:0] NOM = NOMINAL[g][PERIOD_W-1:0];
        localparam logic [PERIOD_W-1:0] TOL = NOM >> TOL_SHIFT;
        logic [PERIOD_W-1:0] diff;
        assign diff     = (period >= NOM) ? period - NOM : NOM - period;
        assign match[g] = (diff <= TOL);
    end

    // Lowest matching index wins.
    always_comb begin
        hit = |match;
        if      (match[0]) idx = 3'd0;
        else if (match[1]) idx = 3'd1;
        else if (match[2]) idx = 3'd2;
        else if (match[3]) idx = 3'd3;
        else if (match[4]) idx = 3'd4;
        else if (match[5]) idx = 3'd5;
        else if (match[6]) idx = 3'd6;
        else               idx = 3'd7;
    end

    // ---------------- FSM ----------------
    state_t              state, state_n;
    logic [MW-1:0]       match_cnt, mcnt_n;
    logic [2:0]          cand, cand_n;
    logic [PERIOD_W-1:0] period_n;
    logic                pstb_n, nstb_n, valid_n;
    logic [2:0]          idx_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            match_cnt  <= '0;
            cand       <= '0;
            period_out <= '0;
            period_stb <= 1'b0;
            note_idx   <= '0;
            note_valid <= 1'b0;
            note_stb   <= 1'b0;
            silence    <= 1'b1;
        end else begin
            state      <= state_n;
            match_cnt  <= mcnt_n;
            cand       <= cand_n;
            period_out <= period_n;
            period_stb <= pstb_n;
            note_idx   <= idx_n;
            note_valid <= valid_n;
            note_stb   <= nstb_n;
            silence    <= (state_n == IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        mcnt_n   = match_cnt;
        cand_n   = cand;
        period_n = period_out;
        pstb_n   = 1'b0;
        nstb_n   = 1'b0;
        idx_n    = note_idx;
        valid_n  = note_valid;

        if (state != IDLE && timeout) begin
            // Timeout beats a coincident rise; that rise then arms directly.
            state_n = rise ? ARMED : IDLE;
            valid_n = 1'b0;
            idx_n   = 3'd0;
            mcnt_n  = '0;
        end else if (rise) begin
            if (state == IDLE) begin
                state_n = ARMED;
            end else begin
                period_n = period;
                pstb_n   = 1'b1;
                // match_cnt is 0 in ARMED and after a miss, so "+1" and
                // "restart at 1" coincide there.
                if (!hit) begin
                    mcnt_n = '0;
                end else if (idx == cand) begin
                    mcnt_n = match_cnt + 1'b1;
                end else begin
                    cand_n = idx;
                    mcnt_n = MW'(1);
                end

                if (state == LOCKED && hit && idx == note_idx) begin
                    // Same note again: hold lock untouched.
                    mcnt_n = match_cnt;
                    cand_n = cand;
                end else if (hit && mcnt_n == LOCK_N) begin
                    state_n = LOCKED;
                    idx_n   = cand_n;
                    valid_n = 1'b1;
                    nstb_n  = 1'b1;
                end else begin
                    state_n = LOCKING;
                    valid_n = 1'b0;
                end
            end
        end
    end

endmodule
